// File: rtl/write_control.sv
// Write-side controller of an async FIFO: write pointers, Gray pointer export, read-pointer sync, full/overflow.
// Define WR_LEVEL_EN to add the w_level and almost_full outputs.
module write_control #(
    parameter int ADDR_WIDTH = 3,
    parameter int AF_MARGIN  = 1,
    localparam int PW        = ADDR_WIDTH + 1
) (
    input  logic                  w_clk,
    input  logic                  wrst,
    input  logic                  w_en,
    input  logic [PW-1:0]         g_rptr,
    input  logic                  ovf_clr,
    output logic [PW-1:0]         b_wptr,
    output logic [PW-1:0]         g_wptr,
    output logic [ADDR_WIDTH-1:0] w_addr,
    output logic                  mem_we,
    output logic                  full,
    output logic                  ovf
`ifdef WR_LEVEL_EN
    ,
    output logic [PW-1:0]         w_level,
    output logic                  almost_full
`endif
);

    logic [PW-1:0] g_rptr_meta;
    logic [PW-1:0] g_rptr_sync;
    logic [PW-1:0] b_wptr_next;
    logic [PW-1:0] g_wptr_next;
    logic [PW-1:0] g_rptr_full;
    logic          accept;

    // Plain two-flop synchronizer; nothing may sit between the flops.
    always_ff @(posedge w_clk or posedge wrst) begin
        if (wrst) begin
            g_rptr_meta <= '0;
            g_rptr_sync <= '0;
        end else begin
            g_rptr_meta <= g_rptr;
            g_rptr_sync <= g_rptr_meta;
        end
    end

    // Handshake: w_en is the producer's valid, ~full is our ready; a write
    // transfers in any cycle where both are high, and mem_we marks exactly that cycle.
    assign accept      = w_en & ~full;
    assign mem_we      = accept;
    assign b_wptr_next = b_wptr + {{(PW-1){1'b0}}, accept};
    assign g_wptr_next = (b_wptr_next >> 1) ^ b_wptr_next;
    assign g_rptr_full = {~g_rptr_sync[PW-1:PW-2], g_rptr_sync[PW-3:0]};
    assign w_addr      = b_wptr[ADDR_WIDTH-1:0];

    always_ff @(posedge w_clk or posedge wrst) begin
        if (wrst) begin
            b_wptr <= '0;
            g_wptr <= '0;
            full   <= 1'b0;
        end else begin
            b_wptr <= b_wptr_next;
            g_wptr <= g_wptr_next;
            full   <= (g_wptr_next == g_rptr_full);
        end
    end

    // Setting wins over clearing so a refused write is never lost.
    always_ff @(posedge w_clk or posedge wrst) begin
        if (wrst) begin
            ovf <= 1'b0;
        end else if (w_en & full) begin
            ovf <= 1'b1;
        end else if (ovf_clr) begin
            ovf <= 1'b0;
        end
    end

`ifdef WR_LEVEL_EN
    localparam int            DEPTH    = 1 << ADDR_WIDTH;
    localparam logic [PW-1:0] AF_LEVEL = PW'(DEPTH - AF_MARGIN);

    function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
        logic [PW-1:0] b;
        b[PW-1] = g[PW-1];
        for (int i = PW - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    logic [PW-1:0] level_next;
    assign level_next = b_wptr_next - gray2bin(g_rptr_sync);

    always_ff @(posedge w_clk or posedge wrst) begin
        if (wrst) begin
            w_level     <= '0;
            almost_full <= 1'b0;
        end else begin
            w_level     <= level_next;
            almost_full <= (level_next >= AF_LEVEL);
        end
    end
`endif

endmodule

// File: tb/tb_write_control.sv
// Bench for write_control: directed fill/overflow/release table, reset cases, and random traffic vs an occupancy model.
module tb_write_control;

    localparam int AW    = 3;
    localparam int PW    = AW + 1;
    localparam int DEPTH = 1 << AW;
    localparam int AFM   = 1;

    logic          w_clk;
    logic          wrst;
    logic          w_en;
    logic [PW-1:0] g_rptr;
    logic          ovf_clr;
    logic [PW-1:0] b_wptr;
    logic [PW-1:0] g_wptr;
    logic [AW-1:0] w_addr;
    logic          mem_we;
    logic          full;
    logic          ovf;
`ifdef WR_LEVEL_EN
    logic [PW-1:0] w_level;
    logic          almost_full;
`endif

    write_control #(.ADDR_WIDTH(AW), .AF_MARGIN(AFM)) dut (
        .w_clk   (w_clk),
        .wrst    (wrst),
        .w_en    (w_en),
        .g_rptr  (g_rptr),
        .ovf_clr (ovf_clr),
        .b_wptr  (b_wptr),
        .g_wptr  (g_wptr),
        .w_addr  (w_addr),
        .mem_we  (mem_we),
        .full    (full),
        .ovf     (ovf)
`ifdef WR_LEVEL_EN
        ,
        .w_level     (w_level),
        .almost_full (almost_full)
`endif
    );

    // clock / reset
    initial w_clk = 1'b0;
    always #5 w_clk = ~w_clk;

    int n_tests = 0;
    int n_fail  = 0;

    // reference model: plain counts of items written and read
    int   m_wr;
    int   m_rd;
    int   m_r1;    // read count driven one cycle ago
    int   m_r2;    // read count driven two cycles ago
    logic m_full;
    logic m_ovf;
    int   m_level;
    logic [PW-1:0] prev_g;
    logic s_we;
    int   s_addr;

    function automatic logic [PW-1:0] to_gray(input int n);
        logic [PW-1:0] b;
        b = PW'(n % (1 << PW));
        return b ^ (b >> 1);
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_wr = 0; m_rd = 0; m_r1 = 0; m_r2 = 0;
        m_full = 1'b0; m_ovf = 1'b0; m_level = 0;
        prev_g = '0;
    endtask

    task automatic do_reset();
        @(negedge w_clk);
        wrst = 1'b1; w_en = 1'b0; ovf_clr = 1'b0; g_rptr = '0;
        repeat (2) @(negedge w_clk);
        wrst = 1'b0;
        model_reset();
    endtask

    // One write-clock cycle; called just after a falling edge, returns at the next falling edge.
    task automatic cycle(input logic w, input int rd, input logic clr);
        logic acc;
        int   bits;
        w_en    = w;
        ovf_clr = clr;
        m_rd    = rd;
        g_rptr  = to_gray(rd);
        #1;
        acc = w & ~m_full;
        s_we   = mem_we;
        s_addr = int'(w_addr);
        check("mem_we", int'(mem_we), int'(acc));
        check("w_addr", int'(w_addr), m_wr % DEPTH);
        @(posedge w_clk);
        if (acc) m_wr++;
        if (w && m_full) m_ovf = 1'b1;
        else if (clr)    m_ovf = 1'b0;
        m_level = m_wr - m_r2;
        m_full  = (m_level == DEPTH);
        m_r2 = m_r1;
        m_r1 = rd;
        #1;
        check("b_wptr", int'(b_wptr), m_wr % (1 << PW));
        check("g_wptr", int'(g_wptr), int'(to_gray(m_wr)));
        check("full", int'(full), int'(m_full));
        check("ovf", int'(ovf), int'(m_ovf));
        bits = $countones(prev_g ^ g_wptr);
        check("g_wptr_one_bit", int'(bits <= 1), 1);
        prev_g = g_wptr;
`ifdef WR_LEVEL_EN
        check("w_level", int'(w_level), m_level);
        check("almost_full", int'(almost_full), int'(m_level >= DEPTH - AFM));
`endif
        @(negedge w_clk);
    endtask

    typedef struct {
        logic w;
        int   rd;
        logic clr;
        logic e_we;
        int   e_addr;
        int   e_b;
        logic e_full;
        logic e_ovf;
    } vec_t;

    vec_t tbl[16];
    logic wrap_seen;
    logic full_seen;
    logic [PW-1:0] last_b;

    initial begin
        wrst = 1'b1; w_en = 1'b0; ovf_clr = 1'b0; g_rptr = '0;
        model_reset();
        #1;
        check("rst_b_wptr", int'(b_wptr), 0);
        check("rst_g_wptr", int'(g_wptr), 0);
        check("rst_full", int'(full), 0);
        check("rst_ovf", int'(ovf), 0);

        // fill, overflow, clear, release
        for (int i = 0; i < 8; i++)
            tbl[i] = '{1'b1, 0, 1'b0, 1'b1, i, i + 1, (i == 7), 1'b0};
        tbl[8]  = '{1'b1, 0, 1'b0, 1'b0, 0, 8, 1'b1, 1'b1};
        tbl[9]  = '{1'b1, 0, 1'b0, 1'b0, 0, 8, 1'b1, 1'b1};
        tbl[10] = '{1'b0, 0, 1'b1, 1'b0, 0, 8, 1'b1, 1'b0};
        tbl[11] = '{1'b1, 0, 1'b1, 1'b0, 0, 8, 1'b1, 1'b1};
        tbl[12] = '{1'b0, 1, 1'b1, 1'b0, 0, 8, 1'b1, 1'b0};
        tbl[13] = '{1'b0, 1, 1'b0, 1'b0, 0, 8, 1'b1, 1'b0};
        tbl[14] = '{1'b0, 1, 1'b0, 1'b0, 0, 8, 1'b0, 1'b0};
        tbl[15] = '{1'b1, 1, 1'b0, 1'b1, 0, 9, 1'b1, 1'b0};

        do_reset();
        for (int i = 0; i < 16; i++) begin
            cycle(tbl[i].w, tbl[i].rd, tbl[i].clr);
            check($sformatf("tbl%0d_we", i), int'(s_we), int'(tbl[i].e_we));
            check($sformatf("tbl%0d_addr", i), s_addr, tbl[i].e_addr);
            check($sformatf("tbl%0d_b", i), int'(b_wptr), tbl[i].e_b);
            check($sformatf("tbl%0d_full", i), int'(full), int'(tbl[i].e_full));
            check($sformatf("tbl%0d_ovf", i), int'(ovf), int'(tbl[i].e_ovf));
            if (i == 7) check("fill_g_wptr", int'(g_wptr), 12);
`ifdef WR_LEVEL_EN
            if (i == 6) begin
                check("lvl7", int'(w_level), 7);
                check("af7", int'(almost_full), 1);
            end
            if (i == 7) check("lvl8", int'(w_level), 8);
`endif
        end

        // asynchronous reset in the middle of a run with b_wptr = 5
        do_reset();
        for (int i = 0; i < 5; i++) cycle(1'b1, 0, 1'b0);
        check("pre_rst_b", int'(b_wptr), 5);
        w_en = 1'b0;
        #2 wrst = 1'b1;
        #1;
        check("mid_rst_b", int'(b_wptr), 0);
        check("mid_rst_g", int'(g_wptr), 0);
        check("mid_rst_addr", int'(w_addr), 0);
        check("mid_rst_we", int'(mem_we), 0);
        check("mid_rst_full", int'(full), 0);
        check("mid_rst_ovf", int'(ovf), 0);
        w_en = 1'b1;
        @(posedge w_clk);
        #1;
        check("rst_hold_b", int'(b_wptr), 0);
        @(negedge w_clk);
        wrst = 1'b0;
        model_reset();
        cycle(1'b1, 0, 1'b0);
        check("first_wr_addr", s_addr, 0);
        check("first_wr_b", int'(b_wptr), 1);

        // 40 writes with matching reads: pointers wrap, full never set
        do_reset();
        wrap_seen = 1'b0; full_seen = 1'b0; last_b = '0;
        for (int i = 0; i < 40; i++) begin
            cycle(1'b1, (m_rd < m_wr) ? m_rd + 1 : m_rd, 1'b0);
            if (last_b == 4'hf && b_wptr == 4'h0) wrap_seen = 1'b1;
            if (full) full_seen = 1'b1;
            last_b = b_wptr;
        end
        check("wrap_seen", int'(wrap_seen), 1);
        check("no_false_full", int'(full_seen), 0);

        // random traffic
        for (int i = 0; i < 600; i++) begin
            logic w;
            logic clr;
            int   rd;
            w   = ($urandom_range(0, 99) < 65);
            clr = ($urandom_range(0, 15) == 0);
            rd  = (m_rd < m_wr && $urandom_range(0, 99) < 50) ? m_rd + 1 : m_rd;
            cycle(w, rd, clr);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/write_control.md
WRITE_CONTROL -- requirements
Module: write_control

Interface
REQ-001 Parameter ADDR_WIDTH, default 3, SHALL set FIFO depth DEPTH = 2**ADDR_WIDTH; pointers are ADDR_WIDTH+1 bits wide (PW).
REQ-002 Parameter AF_MARGIN, default 1, SHALL set the almost-full threshold (used only under WR_LEVEL_EN).
REQ-003 w_clk  input  1  write-domain clock; all state SHALL be on its rising edge.
REQ-004 wrst  input  1  reset: asynchronous assert, active-high; held low for normal operation.
REQ-005 w_en  input  1  write request from the producer.
REQ-006 g_rptr  input  PW  read-domain Gray read pointer, asynchronous to w_clk.
REQ-007 b_wptr  output  PW  registered binary write pointer.
REQ-008 g_wptr  output  PW  registered Gray write pointer, sent to the read domain.
REQ-009 w_addr  output  ADDR_WIDTH  memory write address = b_wptr[ADDR_WIDTH-1:0].
REQ-010 mem_we  output  1  memory write strobe for the current cycle.
REQ-011 full  output  1  registered full flag.
REQ-012 ovf  output  1  sticky overflow flag.
REQ-013 ovf_clr  input  1  synchronous clear of ovf.

Function
REQ-014 g_rptr SHALL pass through a 2-flop synchronizer in w_clk, giving g_rptr_sync; no logic between the two flops.
REQ-015 accept = w_en & ~full; mem_we SHALL equal accept combinationally.
REQ-016 b_wptr_next = b_wptr + accept (mod 2**PW); g_wptr_next = (b_wptr_next >> 1) ^ b_wptr_next; both registered every cycle.
REQ-017 full SHALL register (g_wptr_next == {~g_rptr_sync[PW-1:PW-2], g_rptr_sync[PW-3:0]}).
REQ-018 full SHALL assert in the cycle after the accepted write that fills slot DEPTH; no write accepted while full.
REQ-019 After a read frees a slot, full SHALL deassert no earlier than 3 w_clk edges after g_rptr changes (2 sync + 1 register).
REQ-020 w_en while full SHALL leave pointers unchanged, keep mem_we low, and set ovf on the next edge.
REQ-021 ovf SHALL stay set until ovf_clr; set and clear in the same cycle -> ovf stays 1.
REQ-022 Pointer wrap: b_wptr from 2**PW-1 to 0 on accept SHALL be seamless; full/empty comparison stays correct across wraps.

Reset
REQ-023 wrst high SHALL immediately force b_wptr=0, g_wptr=0, both sync flops=0, full=0, ovf=0 (and w_level=0, almost_full=0 when compiled in).
REQ-024 wrst asserted mid-write SHALL discard that write's pointer update; mem_we follows w_en & ~full and is don't-care for memory during reset.
REQ-025 First write SHALL be accepted on the first rising edge after wrst deasserts.

Configuration
REQ-026 Macro WR_LEVEL_EN defined: outputs w_level (PW bits) and almost_full SHALL exist.
REQ-027 w_level SHALL register b_wptr_next - gray2bin(g_rptr_sync) (mod 2**PW), range 0..DEPTH.
REQ-028 almost_full SHALL register (that same difference >= DEPTH - AF_MARGIN).
REQ-029 Macro undefined: w_level and almost_full ports and logic SHALL be absent; all other behaviour identical.

Verification
REQ-030 Reset: wrst=1 mid-run with b_wptr=5 -> all outputs 0 before next w_clk edge; first write after release gives w_addr=0.
REQ-031 Fill: ADDR_WIDTH=3, g_rptr held 0, w_en=1 for 8 cycles -> w_addr 0..7, full=1 after 8th write, b_wptr=8, g_wptr=4'b1100.
REQ-032 Overflow: full=1, w_en=1 for 2 cycles -> mem_we=0, b_wptr stays 8, ovf=1; ovf_clr pulse -> ovf=0; ovf_clr with w_en & full -> ovf stays 1.
REQ-033 Release: full, g_rptr changes 0 -> 1 (Gray) -> full=0 exactly 3 edges later; next write accepted at w_addr=0, b_wptr=9.
REQ-034 Wrap: 40 writes interleaved with matching reads -> b_wptr wraps 15 -> 0, full never falsely asserts, g_wptr changes one bit per step.
REQ-035 WR_LEVEL_EN, AF_MARGIN=1: 7 writes with g_rptr=0 -> w_level=7, almost_full=1, full=0; 8th -> w_level=8, full=1.
